bfly_switch_2x2: RTL and testbench

BFLY_SWITCH_2X2 -- requirements
Module: bfly_switch_2x2

---
 rtl/noc_pkg.sv | 23 ++
 rtl/noc_sync_fifo.sv | 78 +++++++
 rtl/bfly_switch_2x2.sv | 129 ++++++++++++
 tb/tb_bfly_switch_2x2.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, route-bit position and the
// round-robin pointer type used by the switch arbiters.
package noc_pkg;

  localparam int NOC_DATA_WIDTH  = 8;
  localparam int NOC_ADDR_LENGTH = 8;

  typedef struct packed {
    logic [NOC_ADDR_LENGTH-1:0] addr;
    logic [NOC_DATA_WIDTH-1:0]  data;
  } flit_t;

  typedef enum logic {
    RR_IN0 = 1'b0,
    RR_IN1 = 1'b1
  } rr_ptr_t;

  // Each switch stage consumes the most significant address bit.
  function automatic int route_bit(input int addr_length);
    return addr_length - 1;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered, reset-gated
// write-ready flag.
module noc_sync_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_pop,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      wr_ptr_next_s;
  logic [AW:0]      rd_ptr_next_s;
  logic             ready_r;
  logic             push_s;
  logic             pop_s;
  logic             empty_s;
  logic             full_next_s;

  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign push_s   = wr_valid & ready_r;
  assign pop_s    = rd_pop & ~empty_s;
  assign wr_ready = ready_r;
  assign rd_valid = ~empty_s;
  assign rd_data  = mem_r[rd_ptr_r[AW-1:0]];

  // Next pointer values; ready is recomputed from these so it is a pure register.
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    if (push_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    full_next_s = (wr_ptr_next_s[AW] != rd_ptr_next_s[AW]) &&
                  (wr_ptr_next_s[AW-1:0] == rd_ptr_next_s[AW-1:0]);
  end

  // Pointer and ready-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      ready_r  <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      ready_r  <= ~full_next_s;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/bfly_switch_2x2.sv
// 2x2 butterfly switch element: buffered inputs, MSB-routed heads,
// round-robin arbitration per output and one output register stage.
module bfly_switch_2x2
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_LENGTH = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    in_valid,
  output logic [1:0]                    in_ready,
  input  logic [2*DATA_WIDTH-1:0]       in_data,
  input  logic [2*ADDR_LENGTH-1:0]      in_addr,
  output logic [1:0]                    out_valid,
  input  logic [1:0]                    out_ready,
  output logic [2*DATA_WIDTH-1:0]       out_data,
  output logic [2*(ADDR_LENGTH-1)-1:0]  out_addr
);

  localparam int ROUTE_BIT = route_bit(ADDR_LENGTH);
  localparam int FLIT_W    = ADDR_LENGTH + DATA_WIDTH;
  localparam int OA_W      = ADDR_LENGTH - 1;

  typedef struct packed {
    logic [ADDR_LENGTH-1:0] addr;
    logic [DATA_WIDTH-1:0]  data;
  } port_flit_t;

  port_flit_t            head_s [2];
  logic [1:0]            head_valid_s;
  logic [1:0]            req_s [2];
  logic [1:0]            pop_s;
  logic [1:0]            load_s;
  logic [1:0]            grant_valid_s;
  logic [1:0]            contested_s;
  rr_ptr_t               winner_s [2];
  rr_ptr_t               rr_ptr_r [2];
  logic [1:0]            out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r [2];
  logic [OA_W-1:0]       out_addr_r [2];

  for (genvar p = 0; p < 2; p++) begin : g_in
    logic [FLIT_W-1:0] rd_data_s;

    noc_sync_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (in_valid[p]),
      .wr_ready (in_ready[p]),
      .wr_data  ({in_addr[p*ADDR_LENGTH +: ADDR_LENGTH], in_data[p*DATA_WIDTH +: DATA_WIDTH]}),
      .rd_valid (head_valid_s[p]),
      .rd_pop   (pop_s[p]),
      .rd_data  (rd_data_s)
    );

    assign head_s[p] = port_flit_t'(rd_data_s);
  end

  // An output register may take a new flit when empty or being drained.
  assign load_s = ~out_valid_r | out_ready;

  // Request matching and per-output winner selection.
  always_comb begin
    pop_s         = 2'b00;
    grant_valid_s = 2'b00;
    contested_s   = 2'b00;
    req_s[0]      = 2'b00;
    req_s[1]      = 2'b00;
    winner_s[0]   = RR_IN0;
    winner_s[1]   = RR_IN0;
    for (int o = 0; o < 2; o++) begin
      for (int p = 0; p < 2; p++) begin
        req_s[o][p] = head_valid_s[p] & (head_s[p].addr[ROUTE_BIT] == 1'(o));
      end
      case (req_s[o])
        2'b11: begin
          contested_s[o] = 1'b1;
          winner_s[o]    = rr_ptr_r[o];
        end
        2'b10:   winner_s[o] = RR_IN1;
        2'b01:   winner_s[o] = RR_IN0;
        default: winner_s[o] = RR_IN0;
      endcase
      grant_valid_s[o]     = load_s[o] & (req_s[o] != 2'b00);
      pop_s[winner_s[o]]   = pop_s[winner_s[o]] | grant_valid_s[o];
    end
  end

  // Output valid flags and round-robin pointers; pointer moves only on contested grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 2'b00;
      rr_ptr_r[0] <= RR_IN0;
      rr_ptr_r[1] <= RR_IN0;
    end else begin
      for (int o = 0; o < 2; o++) begin
        if (load_s[o]) begin
          out_valid_r[o] <= grant_valid_s[o];
        end
        if (load_s[o] && contested_s[o]) begin
          rr_ptr_r[o] <= (rr_ptr_r[o] == RR_IN0) ? RR_IN1 : RR_IN0;
        end
      end
    end
  end

  // Output payload registers; address loses the bit consumed by this stage.
  always_ff @(posedge clk) begin
    for (int o = 0; o < 2; o++) begin
      if (grant_valid_s[o]) begin
        out_data_r[o] <= head_s[winner_s[o]].data;
        out_addr_r[o] <= head_s[winner_s[o]].addr[OA_W-1:0];
      end
    end
  end

  assign out_valid = out_valid_r;

  for (genvar o = 0; o < 2; o++) begin : g_out
    assign out_data[o*DATA_WIDTH +: DATA_WIDTH] = out_data_r[o];
    assign out_addr[o*OA_W +: OA_W]             = out_addr_r[o];
  end

endmodule

// File: tb/tb_bfly_switch_2x2.sv
// Self-checking bench for bfly_switch_2x2: directed phases plus random
// traffic compared cycle by cycle against a queue-based reference model.
module tb_bfly_switch_2x2;

  localparam int DW = 8;
  localparam int AL = 8;
  localparam int FD = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           in_valid;
  logic [1:0]           in_ready;
  logic [2*DW-1:0]      in_data;
  logic [2*AL-1:0]      in_addr;
  logic [1:0]           out_valid;
  logic [1:0]           out_ready;
  logic [2*DW-1:0]      out_data;
  logic [2*(AL-1)-1:0]  out_addr;

  bfly_switch_2x2 #(
    .DATA_WIDTH  (DW),
    .ADDR_LENGTH (AL),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AL-1:0] addr;
    logic [DW-1:0] data;
  } flit_t;

  flit_t      q0[$];
  flit_t      q1[$];
  flit_t      m_out [2];
  logic [1:0] m_valid;
  logic [1:0] m_ready;
  logic [1:0] m_prio;
  int         n_cmp = 0;
  int         n_err = 0;
  int         dlv   = 0;

  // Reference model: one clock edge of the switch, from its external rules.
  task automatic model_edge();
    flit_t      h [2];
    logic [1:0] hv;
    logic [1:0] pop;
    int         win;
    logic       want0, want1;
    if (rst) begin
      q0.delete();
      q1.delete();
      m_valid = 2'b00;
      m_ready = 2'b00;
      m_prio  = 2'b00;
      return;
    end
    hv  = {q1.size() > 0, q0.size() > 0};
    h[0] = hv[0] ? q0[0] : '0;
    h[1] = hv[1] ? q1[0] : '0;
    pop = 2'b00;
    for (int o = 0; o < 2; o++) begin
      if (!m_valid[o] || out_ready[o]) begin
        want0 = hv[0] && (h[0].addr[AL-1] == (o == 1));
        want1 = hv[1] && (h[1].addr[AL-1] == (o == 1));
        win = want1 ? 1 : 0;
        if (want0 && want1) begin
          win = int'(m_prio[o]);
          m_prio[o] = ~m_prio[o];
        end
        if (want0 || want1) begin
          m_valid[o] = 1'b1;
          m_out[o]   = h[win];
          pop[win]   = 1'b1;
        end else begin
          m_valid[o] = 1'b0;
        end
      end
    end
    if (pop[0]) void'(q0.pop_front());
    if (pop[1]) void'(q1.pop_front());
    if (in_valid[0] && m_ready[0]) q0.push_back({in_addr[AL-1:0], in_data[DW-1:0]});
    if (in_valid[1] && m_ready[1]) q1.push_back({in_addr[2*AL-1:AL], in_data[2*DW-1:DW]});
    m_ready[0] = (q0.size() < FD);
    m_ready[1] = (q1.size() < FD);
  endtask

  task automatic check(input string tag);
    n_cmp++;
    assert (in_ready === m_ready) else begin
      n_err++;
      $error("FAIL %s in_ready: observed=%b expected=%b", tag, in_ready, m_ready);
    end
    n_cmp++;
    assert (out_valid === m_valid) else begin
      n_err++;
      $error("FAIL %s out_valid: observed=%b expected=%b", tag, out_valid, m_valid);
    end
    for (int o = 0; o < 2; o++) begin
      if (m_valid[o]) begin
        n_cmp++;
        assert (out_data[o*DW +: DW] === m_out[o].data) else begin
          n_err++;
          $error("FAIL %s out_data[%0d]: observed=%h expected=%h", tag, o, out_data[o*DW +: DW], m_out[o].data);
        end
        n_cmp++;
        assert (out_addr[o*(AL-1) +: (AL-1)] === m_out[o].addr[AL-2:0]) else begin
          n_err++;
          $error("FAIL %s out_addr[%0d]: observed=%h expected=%h", tag, o, out_addr[o*(AL-1) +: (AL-1)], m_out[o].addr[AL-2:0]);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    dlv += $countones(out_valid & out_ready);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic drive(input logic [1:0] v, input logic [AL-1:0] a0, input logic [DW-1:0] d0,
                       input logic [AL-1:0] a1, input logic [DW-1:0] d1);
    in_valid = v;
    in_addr  = {a1, a0};
    in_data  = {d1, d0};
  endtask

  task automatic idle(input int n, input string tag);
    drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    int acc;
    rst       = 1'b1;
    out_ready = 2'b11;
    drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    step("reset");
    step("reset");
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    step("release");
    chk("release_in_ready", 32'(in_ready), 32'h3);

    // Single flit, port 0 to output 1.
    drive(2'b01, 8'h80, 8'hA5, 8'h00, 8'h00);
    step("single");
    idle(1, "single");
    chk("single_valid", 32'(out_valid), 32'h2);
    chk("single_data", 32'(out_data[15:8]), 32'hA5);
    chk("single_addr", 32'(out_addr[13:7]), 32'h00);
    idle(2, "single_drain");

    // Contention on output 0: port 0 wins first, then the pointer favours port 1.
    drive(2'b11, 8'h05, 8'h11, 8'h06, 8'h22);
    step("contend");
    idle(1, "contend");
    chk("contend_first", 32'(out_data[7:0]), 32'h11);
    idle(1, "contend");
    chk("contend_second", 32'(out_data[7:0]), 32'h22);
    idle(2, "contend_drain");
    drive(2'b11, 8'h01, 8'h33, 8'h02, 8'h44);
    step("contend2");
    idle(1, "contend2");
    chk("contend2_first", 32'(out_data[7:0]), 32'h44);
    idle(3, "contend2_drain");

    // Parallel streams to distinct outputs.
    dlv = 0;
    for (int i = 0; i < 10; i++) begin
      drive(2'b11, 8'($urandom_range(0, 127)), 8'($urandom), 8'($urandom_range(128, 255)), 8'($urandom));
      step("parallel");
    end
    idle(4, "parallel_drain");
    chk("parallel_count", 32'(dlv), 32'd20);

    // Backpressure: fill the output register and the FIFO.
    out_ready = 2'b00;
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, 8'($urandom_range(0, 127)), 8'(8'h60 + i), 8'h00, 8'h00);
      step("backpressure");
      if (i == 4) chk("full_in_ready0", 32'(in_ready[0]), 32'h0);
    end
    dlv = 0;
    out_ready = 2'b11;
    idle(8, "bp_drain");
    chk("bp_count", 32'(dlv), 32'd5);

    // Stream through port 1 with random downstream readiness.
    acc = 0;
    dlv = 0;
    for (int c = 0; c < 300 && acc < 16; c++) begin
      out_ready = 2'($urandom_range(0, 3));
      drive(2'b10, 8'h00, 8'h00, 8'($urandom), 8'(8'h40 + acc));
      if (m_ready[1]) acc++;
      step("stream");
    end
    chk("stream_accepted", 32'(acc), 32'd16);
    out_ready = 2'b11;
    idle(8, "stream_drain");
    chk("stream_count", 32'(dlv), 32'd16);

    // Random mixed traffic.
    for (int c = 0; c < 150; c++) begin
      out_ready = 2'($urandom_range(0, 3));
      drive(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      step("random");
    end
    out_ready = 2'b11;
    idle(8, "random_drain");

    // Reset with flits buffered.
    out_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 8'h00, 8'(8'h90 + i), 8'h00, 8'h00);
      step("pre_reset");
    end
    idle(1, "pre_reset");
    rst = 1'b1;
    step("mid_reset");
    chk("mid_reset_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    out_ready = 2'b11;
    dlv = 0;
    idle(8, "post_reset");
    chk("post_reset_count", 32'(dlv), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
